// File: rtl/pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer
//
// Brings up the pixel-clock PLL from the board oscillator domain. The PLL is
// held in reset for a fixed time and then released. The sequencer waits for
// LOCK, then requires LOCK to stay high for a run of consecutive cycles
// before it raises ready. A lock timeout triggers a retry. When retries are
// exhausted, the sequencer latches a fault. A loss of lock while running
// drops ready and restarts the sequence.
//
// Ports
//   clk         board oscillator clock, the only clock
//   rst_n       synchronous active-low reset
//   en          1 lets the PLL run; 0 forces HOLD (FAULT is unaffected)
//   relock_req  one-cycle pulse that restarts the sequence and clears FAULT
//   pll_lock    raw PLL LOCK; asynchronous, synchronised here through two flops
//   pll_resetb  drives PLL RESETB; 0 holds the PLL in reset
//   ready       PLL locked and stable
//   fault       retries exhausted; sticky until relock_req or reset
//   lock_lost   one-cycle pulse when the synchronised lock falls during RUN
//   retries     failed lock attempts in the current sequence
//   state       debug view: HOLD=0 WAIT_LOCK=1 STABLE=2 RUN=3 FAULT=4
// ---------------------------------------------------------------------------
module pll_lock_sequencer #(
   parameter int HOLD_CYCLES   = 16,
   parameter int LOCK_TIMEOUT  = 1600,
   parameter int STABLE_CYCLES = 256,
   parameter int MAX_RETRIES   = 3,
   parameter int RW            = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          relock_req,
   input  logic          pll_lock,
   output logic          pll_resetb,
   output logic          ready,
   output logic          fault,
   output logic          lock_lost,
   output logic [RW-1:0] retries,
   output logic [2:0]    state
);

   // One shared counter serves all three timed phases, so it is sized for
   // the longest of them.
   localparam int CNT_MAX_A = (HOLD_CYCLES > LOCK_TIMEOUT) ? HOLD_CYCLES : LOCK_TIMEOUT;
   localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
   localparam int CW        = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

   typedef enum logic [2:0] {
      ST_HOLD      = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAULT     = 3'd4
   } state_t;

   // Increment that sticks at the given limit. HOLD uses it so that a long
   // en=0 period leaves the counter parked at its terminal value.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v,
                                             input logic [CW-1:0] lim);
      sat_inc = (v >= lim) ? lim : v + 1'b1;
   endfunction

   logic          lock_p0;
   logic          lock_p1;
   logic          lock_s;
   state_t        st_q;
   state_t        st_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [RW-1:0] ret_nxt;
   logic          lost_nxt;

   assign lock_s = lock_p1;
   assign state  = st_q;

   // ---- stage p0/p1: two-flop synchroniser for the asynchronous LOCK ----

   // ---- next-state decode ----
   always_comb begin
      st_nxt   = st_q;
      cnt_nxt  = cnt;
      ret_nxt  = retries;
      // The lock-loss pulse does not depend on which transition wins the
      // priority below. en=0 or relock_req in the same cycle still report it.
      lost_nxt = (st_q == ST_RUN) && !lock_s;

      if (!en && (st_q != ST_FAULT)) begin
         st_nxt = ST_HOLD;
         // Staying in HOLD is not a re-entry. The counter keeps saturating,
         // so HOLD can be left as soon as en returns.
         cnt_nxt = (st_q == ST_HOLD) ? sat_inc(cnt, HOLD_LAST) : '0;
      end else if (relock_req) begin
         st_nxt  = ST_HOLD;
         cnt_nxt = '0;
         ret_nxt = '0;
      end else begin
         unique case (st_q)
            ST_HOLD: begin
               if (cnt == HOLD_LAST) begin
                  st_nxt  = ST_WAIT_LOCK;
                  cnt_nxt = '0;
               end else begin
                  cnt_nxt = sat_inc(cnt, HOLD_LAST);
               end
            end
            ST_WAIT_LOCK: begin
               if (lock_s) begin
                  st_nxt  = ST_STABLE;
                  cnt_nxt = '0;
               end else if (cnt == TIMEOUT_LAST) begin
                  cnt_nxt = '0;
                  if (retries == RETRY_LIMIT) begin
                     st_nxt = ST_FAULT;
                  end else begin
                     st_nxt  = ST_HOLD;
                     ret_nxt = retries + 1'b1;
                  end
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            ST_STABLE: begin
               // A dropout while qualifying is treated as a chatter event.
               // The PLL is not reset and no retry is charged.
               if (!lock_s) begin
                  st_nxt  = ST_WAIT_LOCK;
                  cnt_nxt = '0;
               end else if (cnt == STABLE_LAST) begin
                  st_nxt  = ST_RUN;
                  cnt_nxt = '0;
                  ret_nxt = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            ST_RUN: begin
               if (!lock_s) begin
                  st_nxt  = ST_HOLD;
                  cnt_nxt = '0;
               end
            end
            ST_FAULT: begin
               st_nxt = ST_FAULT;
            end
            default: begin
               st_nxt  = ST_HOLD;
               cnt_nxt = '0;
            end
         endcase
      end
   end

   // ---- state register with outputs decoded from the next state ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock_p0    <= 1'b0;
         lock_p1    <= 1'b0;
         st_q       <= ST_HOLD;
         cnt        <= '0;
         retries    <= '0;
         lock_lost  <= 1'b0;
         pll_resetb <= 1'b0;
         ready      <= 1'b0;
         fault      <= 1'b0;
      end else begin
         lock_p0    <= pll_lock;
         lock_p1    <= lock_p0;
         st_q       <= st_nxt;
         cnt        <= cnt_nxt;
         retries    <= ret_nxt;
         lock_lost  <= lost_nxt;
         pll_resetb <= (st_nxt == ST_WAIT_LOCK) || (st_nxt == ST_STABLE) ||
                       (st_nxt == ST_RUN);
         ready      <= (st_nxt == ST_RUN);
         fault      <= (st_nxt == ST_FAULT);
      end
   end

endmodule
